// File: rtl/stream_rr_arbiter.sv
// Four-way round-robin stb/ack stream merger with bounded per-grant bursts.
// Each merged word carries a 2-bit source tag so the consumer can demultiplex.
module stream_rr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  input  logic [WIDTH-1:0] input_c,
  input  logic             input_c_stb,
  output logic             input_c_ack,
  input  logic [WIDTH-1:0] input_d,
  input  logic             input_d_stb,
  output logic             input_d_ack,
  output logic [WIDTH-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic [1:0]       output_z_src,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCEPT, SEND} state_t;

  state_t                 state;
  logic [1:0]             ptr;
  logic [1:0]             grant;
  logic [7:0]             burst_cnt;
  logic [3:0]             ack;
  logic [3:0]             stb;
  logic [3:0][WIDTH-1:0]  data;
  logic                   found;
  logic [1:0]             pick;

  assign stb  = {input_d_stb, input_c_stb, input_b_stb, input_a_stb};
  assign data = {input_d, input_c, input_b, input_a};

  assign input_a_ack = ack[0];
  assign input_b_ack = ack[1];
  assign input_c_ack = ack[2];
  assign input_d_ack = ack[3];
  assign busy        = (state != IDLE);

  // Walk from the far end back toward ptr so the closest requester wins.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (stb[ptr + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      grant        <= 2'd0;
      burst_cnt    <= 8'd0;
      ack          <= 4'b0000;
      output_z     <= '0;
      output_z_stb <= 1'b0;
      output_z_src <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= pick;
            burst_cnt <= 8'd0;
            ack       <= 4'b0001 << pick;
            state     <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (stb[grant]) begin
            output_z     <= data[grant];
            output_z_src <= grant;
            ack          <= 4'b0000;
            output_z_stb <= 1'b1;
            burst_cnt    <= burst_cnt + 8'd1;
            state        <= SEND;
          end
        end
        SEND: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            // Keep the grant only while the burst has room and the source still has data.
            if (burst_cnt < 8'(MAX_BURST) && stb[grant]) begin
              ack   <= 4'b0001 << grant;
              state <= ACCEPT;
            end else begin
              ptr   <= grant + 2'd1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: queue-driven sources, an owner/word-level model
// checked every cycle, and literal expected output sequences per scenario.
module tb_stream_rr_arbiter;
  localparam int MAXB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       stb_d = '0;
  logic [3:0][15:0] data_d = '0;
  logic             oack = 1'b1;
  logic             oack_cfg = 1'b1;
  logic             input_a_ack, input_b_ack, input_c_ack, input_d_ack;
  logic [15:0]      output_z;
  logic             output_z_stb;
  logic [1:0]       output_z_src;
  logic             busy;

  stream_rr_arbiter #(.WIDTH(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .input_a(data_d[0]), .input_a_stb(stb_d[0]), .input_a_ack(input_a_ack),
    .input_b(data_d[1]), .input_b_stb(stb_d[1]), .input_b_ack(input_b_ack),
    .input_c(data_d[2]), .input_c_stb(stb_d[2]), .input_c_ack(input_c_ack),
    .input_d(data_d[3]), .input_d_stb(stb_d[3]), .input_d_ack(input_d_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(oack),
    .output_z_src(output_z_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int ack_cycles = 0;

  logic [15:0] src_q [4][$];
  logic [17:0] log_q [$];
  logic [17:0] exp_q [$];
  logic [3:0]  pend_in = '0;

  // Model: who owns the output, how many words taken, and the word in flight.
  int          m_owner = -1;
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_have = 0;
  logic [15:0] m_word = '0;
  logic [1:0]  m_src = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_ack();
    if (m_owner >= 0 && !m_have) return 4'b0001 << m_owner;
    return 4'b0000;
  endfunction

  always @(negedge clk) begin
    logic [3:0] dack;
    dack = {input_d_ack, input_c_ack, input_b_ack, input_a_ack};
    if (!rst) begin
      chk("rst_ack", {28'd0, dack}, 32'd0);
      chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", {16'd0, output_z}, 32'd0);
      chk("rst_src", {30'd0, output_z_src}, 32'd0);
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_have = 0;
      pend_in = '0;
      stb_d = '0;
    end else begin
      chk("ack", {28'd0, dack}, {28'd0, m_ack()});
      chk("ostb", {31'd0, output_z_stb}, {31'd0, m_have});
      chk("busy", {31'd0, busy}, {31'd0, (m_owner >= 0)});
      if (m_have) begin
        chk("odata", {16'd0, output_z}, {16'd0, m_word});
        chk("osrc", {30'd0, output_z_src}, {30'd0, m_src});
      end
      ack_cycles += $countones(dack);
      for (int i = 0; i < 4; i++)
        if (pend_in[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      for (int i = 0; i < 4; i++) begin
        stb_d[i]  = (src_q[i].size() != 0);
        data_d[i] = stb_d[i] ? src_q[i][0] : 16'h0000;
      end
      oack = oack_cfg;
      pend_in = dack & stb_d;
      if (output_z_stb && oack) log_q.push_back({output_z_src, output_z});
      // Advance the model across the coming rising edge.
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++)
          if (m_owner < 0 && stb_d[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_cnt = 0;
          end
      end else if (!m_have) begin
        if (stb_d[m_owner]) begin
          m_word = data_d[m_owner];
          m_src = 2'(m_owner);
          m_have = 1;
          m_cnt++;
        end
      end else if (oack) begin
        m_have = 0;
        if (!(m_cnt < MAXB && stb_d[m_owner])) begin
          m_ptr = (m_owner + 1) % 4;
          m_owner = -1;
        end
      end
    end
  end

  task automatic wait_log(input int n, input string nm);
    int t = 0;
    while (log_q.size() < n && t < 80) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_timeout"}, {31'd0, (log_q.size() < n)}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic expect_log(input string nm);
    chk({nm, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({nm, "_word"}, {14'd0, log_q[i]}, {14'd0, exp_q[i]});
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ack", {28'd0, input_d_ack, input_c_ack, input_b_ack, input_a_ack}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single word from a.
    ack_cycles = 0;
    src_q[0].push_back(16'h1234);
    wait_log(1, "single");
    chk("single_ack_cycles", ack_cycles, 32'd1);
    chk("single_busy_end", {31'd0, busy}, 32'd0);
    exp_q.push_back({2'd0, 16'h1234});
    expect_log("single");

    // One word each, ptr now at b.
    src_q[0].push_back(16'hA000);
    src_q[1].push_back(16'hB000);
    src_q[2].push_back(16'hC000);
    src_q[3].push_back(16'hD000);
    wait_log(4, "rr");
    exp_q.push_back({2'd1, 16'hB000});
    exp_q.push_back({2'd2, 16'hC000});
    exp_q.push_back({2'd3, 16'hD000});
    exp_q.push_back({2'd0, 16'hA000});
    expect_log("rr");

    // Bursts capped at four, early end when b runs dry.
    for (int i = 0; i < 6; i++) begin
      src_q[0].push_back(16'hA0 + 16'(i));
      src_q[1].push_back(16'hB0 + 16'(i));
    end
    wait_log(12, "burst");
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 16'hB0 + 16'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd0, 16'hA0 + 16'(i)});
    for (int i = 4; i < 6; i++) exp_q.push_back({2'd1, 16'hB0 + 16'(i)});
    for (int i = 4; i < 6; i++) exp_q.push_back({2'd0, 16'hA0 + 16'(i)});
    expect_log("burst");

    // Consumer stall while a word is held.
    oack_cfg = 1'b0;
    src_q[0].push_back(16'h5555);
    repeat (15) @(posedge clk);
    #1;
    chk("stall_stb", {31'd0, output_z_stb}, 32'd1);
    chk("stall_data", {16'd0, output_z}, 32'h5555);
    chk("stall_src", {30'd0, output_z_src}, 32'd0);
    chk("stall_ack", {28'd0, input_d_ack, input_c_ack, input_b_ack, input_a_ack}, 32'd0);
    chk("stall_nolog", log_q.size(), 32'd0);
    oack_cfg = 1'b1;
    wait_log(1, "stall");
    exp_q.push_back({2'd0, 16'h5555});
    expect_log("stall");

    // Serve c so ptr lands on d, then a and b contend: wrap picks a.
    src_q[2].push_back(16'hC111);
    wait_log(1, "c_only");
    exp_q.push_back({2'd2, 16'hC111});
    expect_log("c_only");
    src_q[0].push_back(16'hA222);
    src_q[1].push_back(16'hB333);
    wait_log(2, "wrap");
    exp_q.push_back({2'd0, 16'hA222});
    exp_q.push_back({2'd1, 16'hB333});
    expect_log("wrap");

    // Asynchronous reset while a word sits in SEND.
    oack_cfg = 1'b0;
    src_q[3].push_back(16'h7777);
    for (int t = 0; t < 20 && !output_z_stb; t++) begin
      @(posedge clk); #1;
    end
    chk("areset_pre_stb", {31'd0, output_z_stb}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    #1;
    chk("areset_stb", {31'd0, output_z_stb}, 32'd0);
    chk("areset_ack", {28'd0, input_d_ack, input_c_ack, input_b_ack, input_a_ack}, 32'd0);
    chk("areset_data", {16'd0, output_z}, 32'd0);
    chk("areset_src", {30'd0, output_z_src}, 32'd0);
    chk("areset_busy", {31'd0, busy}, 32'd0);
    oack_cfg = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    log_q.delete();
    src_q[1].push_back(16'hB999);
    src_q[0].push_back(16'hA888);
    wait_log(2, "post_reset");
    exp_q.push_back({2'd0, 16'hA888});
    exp_q.push_back({2'd1, 16'hB999});
    expect_log("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
